// File: rtl/seq_scan_pkg.sv
// Shared definitions for the frame scanner: FSM encoding and default pattern constants.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int                    DEF_WORD_W  = 8;
    localparam int                    DEF_CNT_W   = 4;
    localparam int                    DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1001;

    // Width of a down-counter able to hold w-1; never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_det_mealy.sv
// Bit-serial overlapping pattern detector with a registered Mealy output.
// 'match' is the combinational compare on the current bit; 'hit' is the same
// event delayed by one clock.
module seq_det_mealy
    import seq_scan_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic x,
    output logic match,
    output logic hit
);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] window;
    logic               hit_q, hit_d;

    // Compare the history plus the current bit; advance history only when enabled.
    always_comb begin
        window = {hist_q, x};
        match  = en && (window == PATTERN);
        hit_d  = match;
        hist_d = hist_q;
        if (clr) begin
            hist_d = '0;
        end else if (en) begin
            hist_d = window[PAT_LEN-2:0];
        end
    end

    // History and registered hit flop; async active-low reset clears both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            hit_q  <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame scanner: accepts words over valid/ready, serializes them MSB-first into
// the pattern detector and counts matches per frame with a saturating counter.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_data/in_last are sampled on that edge. in_ready never depends on in_valid,
// and a producer that sees in_ready low must hold its word unchanged.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int                 WORD_W  = DEF_WORD_W,
    parameter int                 CNT_W   = DEF_CNT_W,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              busy,
    output logic              hit,
    output logic [CNT_W-1:0]  match_count,
    output logic              overflow,
    output logic              frame_done
);

    localparam int               IDX_W   = idx_width(WORD_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              last_q, last_d;
    logic              new_frame_q, new_frame_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              word_end;
    logic              accept;
    logic              det_en;
    logic              det_clr;
    logic              det_match;

    assign word_end = (bit_idx_q == '0);
    assign accept   = in_valid && in_ready;

    // Ready in IDLE, or on the final bit of a non-last word so words chain without a bubble.
    always_comb begin
        in_ready = 1'b0;
        if (reset) begin
            if (state_q == ST_IDLE) begin
                in_ready = 1'b1;
            end else if (state_q == ST_SHIFT && word_end && !last_q) begin
                in_ready = 1'b1;
            end
        end
    end

    // Next-state logic: word loading, serialization, frame completion.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        last_d      = last_q;
        new_frame_d = new_frame_q;
        det_en      = 1'b0;
        det_clr     = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d     = in_data;
                    bit_idx_d   = IDX_TOP;
                    last_d      = in_last;
                    new_frame_d = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                det_en    = 1'b1;
                shreg_d   = shreg_q << 1;
                bit_idx_d = bit_idx_q - IDX_W'(1);
                if (word_end) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (accept) begin
                        shreg_d   = in_data;
                        bit_idx_d = IDX_TOP;
                        last_d    = in_last;
                    end else begin
                        // Frame continues later; detector history is kept.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                det_clr     = 1'b1;
                new_frame_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating match counter; cleared by the first word of a new frame.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (state_q == ST_IDLE && accept && new_frame_q) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (det_match) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Control and datapath registers; async active-low reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            last_q      <= 1'b0;
            new_frame_q <= 1'b1;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            last_q      <= last_d;
            new_frame_q <= new_frame_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    seq_det_mealy #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk   (clk),
        .reset (reset),
        .en    (det_en),
        .clr   (det_clr),
        .x     (shreg_q[WORD_W-1]),
        .match (det_match),
        .hit   (hit)
    );

    assign busy        = (state_q != ST_IDLE);
    assign match_count = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: two instances (4-bit and 2-bit counters) share the
// stimulus; a frame-level model predicts counts, overflow, hits and done timing.
module tb_seq_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int MAX_A  = 15;
    localparam int MAX_B  = 3;
    localparam logic [3:0] PAT = 4'b1001;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_last;

    logic       in_ready_a, busy_a, hit_a, overflow_a, frame_done_a;
    logic [3:0] match_count_a;
    logic       in_ready_b, busy_b, hit_b, overflow_b, frame_done_b;
    logic [1:0] match_count_b;

    typedef struct {
        int     count_a;
        int     ovf_a;
        int     count_b;
        int     ovf_b;
        int     hits;
        longint done_cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    bit     frame_bits[$];
    int     checks   = 0;
    int     failures = 0;
    int     hits_a   = 0;
    int     hits_b   = 0;
    longint cyc      = 0;

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .busy(busy_a), .hit(hit_a),
        .match_count(match_count_a), .overflow(overflow_a), .frame_done(frame_done_a)
    );

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .busy(busy_b), .hit(hit_b),
        .match_count(match_count_b), .overflow(overflow_b), .frame_done(frame_done_b)
    );

    // Clock and posedge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count overlapping windows of the frame's bit stream equal to PAT.
    function automatic int count_matches(input bit b[$]);
        int n = 0;
        for (int i = 0; i + 4 <= b.size(); i++) begin
            bit ok = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (b[i+j] != PAT[3-j]) ok = 1'b0;
            end
            if (ok) n++;
        end
        return n;
    endfunction

    function automatic void push_frame(input longint k);
        exp_t e;
        int   m;
        m          = count_matches(frame_bits);
        e.count_a  = (m > MAX_A) ? MAX_A : m;
        e.ovf_a    = (m > MAX_A) ? 1 : 0;
        e.count_b  = (m > MAX_B) ? MAX_B : m;
        e.ovf_b    = (m > MAX_B) ? 1 : 0;
        e.hits     = m;
        // cyc read at a negedge inside the DONE cycle equals acceptance edge + WORD_W.
        e.done_cyc = k + WORD_W;
        exp_q.push_back(e);
        frame_bits.delete();
    endfunction

    // Driver: present a word and hold it until both instances accept it.
    task automatic send_word(input logic [WORD_W-1:0] d, input bit last, output longint k);
        int waited = 0;
        k = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        while (!(in_ready_a && in_ready_b) && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!(in_ready_a && in_ready_b)) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", waited);
            in_valid = 1'b0;
            return;
        end
        k = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = WORD_W - 1; i >= 0; i--) frame_bits.push_back(d[i]);
        if (last) push_frame(k);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready_a"}, in_ready_a, 0);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_hit_a"}, hit_a, 0);
        check({tag, "_count_a"}, match_count_a, 0);
        check({tag, "_ovf_a"}, overflow_a, 0);
        check({tag, "_done_a"}, frame_done_a, 0);
        check({tag, "_in_ready_b"}, in_ready_b, 0);
        check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_hit_b"}, hit_b, 0);
        check({tag, "_count_b"}, match_count_b, 0);
        check({tag, "_ovf_b"}, overflow_b, 0);
        check({tag, "_done_b"}, frame_done_b, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy_a || busy_b) && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_busy"}, busy_a | busy_b, 0);
    endtask

    task automatic idle_gap(input int n);
        wait_idle("gap");
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("gap_busy_a", busy_a, 0);
            check("gap_busy_b", busy_b, 0);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_pending_frames"}, exp_q.size(), 0);
    endtask

    // Monitor: tally hits per frame and score each frame_done against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            hits_a = 0;
            hits_b = 0;
        end else begin
            if (hit_a) hits_a++;
            if (hit_b) hits_b++;
            if (frame_done_a || frame_done_b) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_done: done_a=%0d done_b=%0d, required 0", frame_done_a, frame_done_b);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame_done_a", frame_done_a, 1);
                    check("frame_done_b", frame_done_b, 1);
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("count_a", match_count_a, mon_e.count_a);
                    check("overflow_a", overflow_a, mon_e.ovf_a);
                    check("count_b", match_count_b, mon_e.count_b);
                    check("overflow_b", overflow_b, mon_e.ovf_b);
                    check("hits_a", hits_a, mon_e.hits);
                    check("hits_b", hits_b, mon_e.hits);
                end
                hits_a = 0;
                hits_b = 0;
            end
        end
    end

    // Stimulus: directed frames, mid-frame reset, then random frames.
    initial begin
        longint      k1;
        longint      k2;
        int          nw;
        int          sel;
        logic [7:0]  d;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #2 reset = 1'b1;

        send_word(8'h90, 1'b1, k1);
        send_word(8'b1001_0010, 1'b1, k1);

        send_word(8'b0000_0010, 1'b0, k1);
        send_word(8'b0100_0000, 1'b1, k2);
        check("b2b_accept_edge", k2, k1 + WORD_W);

        send_word(8'b0000_0010, 1'b0, k1);
        idle_gap(5);
        send_word(8'b0100_0000, 1'b1, k2);

        send_word(8'b1001_0010, 1'b0, k1);
        send_word(8'b0100_1001, 1'b1, k1);

        drain("directed");
        send_word(8'b0000_0100, 1'b0, k1);
        wait_idle("pre_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid");
        frame_bits.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        send_word(8'b1000_0000, 1'b1, k1);

        for (int f = 0; f < 30; f++) begin
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       d = 8'b1001_0010;
                    1:       d = 8'b0100_1001;
                    default: d = 8'($urandom_range(0, 255));
                endcase
                send_word(d, (w == nw - 1), k1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        drain("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
